// File: rtl/spi_cfg_ctrl_if.sv
// SPI pin bundle for the configuration controller: chip select, MOSI and MISO.
// The SPI master drives csn/mosi; the controller drives miso.
interface spi_cfg_ctrl_if;
  logic spi_csn;
  logic spi_mosi;
  logic spi_miso;

  modport master (
    output spi_csn,
    output spi_mosi,
    input  spi_miso
  );

  modport slave (
    input  spi_csn,
    input  spi_mosi,
    output spi_miso
  );
endinterface

// File: rtl/spi_cfg_ctrl.sv
// Framed SPI (mode 0) configuration controller: {rw, addr} command byte, then data byte(s),
// committing whole bytes into an addressed register bank. Burst auto-increment: SPI_CFG_AUTOINC_EN.
module spi_cfg_ctrl #(
  parameter int                  NREG      = 8,
  parameter logic [8*NREG-1:0]   DEF_VALUE = 64'h0000_0000_2F1C_CCCD,
  parameter logic [7:0]          ID_VALUE  = 8'hA5
) (
  input  logic                 spi_clk,
  input  logic                 rst,
  spi_cfg_ctrl_if.slave        bus,
  output logic [8*NREG-1:0]    cfg_regs,
  output logic                 cfg_upd_tgl,
  output logic [6:0]           last_addr
);

  localparam logic [6:0] NREG_A  = 7'(NREG);
  localparam logic [6:0] ID_ADDR = 7'h7F;

  typedef enum logic [1:0] {
    ST_CMD,
    ST_DATA,
    ST_DONE
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [2:0]  bcnt;
  logic [2:0]  bcnt_nxt;
  logic        rw;
  logic [6:0]  addr;
  logic [6:0]  cmd_sr;
  logic [6:0]  dat_sr;
  logic [7:0]  rd_sr;
  logic        miso_q;
  logic        cmd_done;
  logic        byte_done;
  logic        commit;
  logic        addr_mapped;
  logic [6:0]  cmd_addr;
  logic [7:0]  wdata;
  logic        csn;
  logic        mosi;

  assign csn          = bus.spi_csn;
  assign mosi         = bus.spi_mosi;
  assign bus.spi_miso = miso_q;

  assign cmd_addr    = {cmd_sr[5:0], mosi};
  assign wdata       = {dat_sr, mosi};
  assign addr_mapped = (addr < NREG_A);
  assign commit      = byte_done && !rw && addr_mapped;

  // Byte presented on MISO for a given address: bank byte, ID byte, or zero when unmapped.
  function automatic logic [7:0] rd_lookup(input logic [6:0] a, input logic [8*NREG-1:0] bank);
    logic [7:0] r;
    r = (a == ID_ADDR) ? ID_VALUE : 8'h00;
    for (int i = 0; i < NREG; i++) begin
      if (a == 7'(i)) r = bank[8*i +: 8];
    end
    return r;
  endfunction

`ifdef SPI_CFG_AUTOINC_EN
  logic [6:0] addr_inc;

  // Mapped addresses wrap at the top of the bank; unmapped ones wrap naturally at 7'h7F.
  always_comb begin
    addr_inc = addr + 7'd1;
    if (addr_mapped && (addr == NREG_A - 7'd1)) addr_inc = 7'd0;
  end
`endif

  // NOTE: every signal assigned in a combinational process gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    bcnt_nxt  = bcnt + 3'd1;
    cmd_done  = 1'b0;
    byte_done = 1'b0;
    case (state)
      ST_CMD: begin
        if (bcnt == 3'd7) begin
          cmd_done  = 1'b1;
          state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bcnt == 3'd7) begin
          byte_done = 1'b1;
`ifdef SPI_CFG_AUTOINC_EN
          state_nxt = ST_DATA;
`else
          state_nxt = ST_DONE;
`endif
        end
      end
      ST_DONE: bcnt_nxt = bcnt;
      default: state_nxt = ST_CMD;
    endcase
  end

  // Chip select high acts as an asynchronous frame abort alongside the system reset.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge spi_clk or posedge rst or posedge csn) begin
    if (rst || csn) begin
      state <= ST_CMD;
      bcnt  <= 3'd0;
      rw    <= 1'b0;
      addr  <= 7'd0;
    end else begin
      state <= state_nxt;
      bcnt  <= bcnt_nxt;
      if (cmd_done) begin
        rw   <= cmd_sr[6];
        addr <= cmd_addr;
      end
`ifdef SPI_CFG_AUTOINC_EN
      else if (byte_done) begin
        addr <= addr_inc;
      end
`endif
    end
  end

  // NOTE: shift registers carry no reset; each is fully refilled before its contents are consumed.
  always_ff @(posedge spi_clk) begin
    if (state == ST_CMD)  cmd_sr <= {cmd_sr[5:0], mosi};
    if (state == ST_DATA) dat_sr <= {dat_sr[5:0], mosi};
    if (cmd_done) begin
      rd_sr <= rd_lookup(cmd_addr, cfg_regs);
    end
`ifdef SPI_CFG_AUTOINC_EN
    else if (byte_done) begin
      rd_sr <= rd_lookup(addr_inc, cfg_regs);
    end
`endif
    else if (state == ST_DATA) begin
      rd_sr <= {rd_sr[6:0], 1'b0};
    end
  end

  // MISO launches on the falling edge so the master samples it stably on the next rising edge.
  always_ff @(negedge spi_clk or posedge rst or posedge csn) begin
    if (rst || csn) begin
      miso_q <= 1'b0;
    end else begin
      miso_q <= (state == ST_DATA) ? rd_sr[7] : 1'b0;
    end
  end

  // Whole-byte commit on the last data bit; consumers never see a partially shifted value.
  always_ff @(posedge spi_clk or posedge rst) begin
    if (rst) begin
      cfg_regs    <= DEF_VALUE;
      cfg_upd_tgl <= 1'b0;
      last_addr   <= 7'd0;
    end else if (commit) begin
      for (int i = 0; i < NREG; i++) begin
        if (addr == 7'(i)) cfg_regs[8*i +: 8] <= wdata;
      end
      cfg_upd_tgl <= ~cfg_upd_tgl;
      last_addr   <= addr;
    end
  end

endmodule
